// File: rtl/rect_raster_engine.sv
// Rectangle rasteriser: clips a box to the visible screen and streams its pixels,
// solid or outline, row-major over a valid/ready pixel interface.
module rect_raster_engine #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int C_W      = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic           iClock,
    input  logic           iReset,
    input  logic           iCmdValid,
    output logic           oCmdReady,
    input  logic [X_W-1:0] iX,
    input  logic [Y_W-1:0] iY,
    input  logic [X_W-1:0] iXs,
    input  logic [Y_W-1:0] iYs,
    input  logic [C_W-1:0] iColour,
    input  logic           iMode,
    output logic           oPlot,
    input  logic           iPixReady,
    output logic [X_W-1:0] oX,
    output logic [Y_W-1:0] oY,
    output logic [C_W-1:0] oColour,
    output logic           oBusy,
    output logic           oDone
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [X_W:0] SCREEN_W_EXT = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] SCREEN_H_EXT = SCREEN_H[Y_W:0];

    state_t         state_reg;
    state_t         state_next;
    logic           armed_reg;
    logic [X_W-1:0] x_reg;
    logic [X_W-1:0] x_first_reg;
    logic [X_W-1:0] x_last_reg;
    logic [Y_W-1:0] y_reg;
    logic [Y_W-1:0] y_first_reg;
    logic [Y_W-1:0] y_last_reg;
    logic [C_W-1:0] colour_reg;
    logic           outline_reg;

    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic [X_W:0]   x_room;
    logic [X_W:0]   eff_w;
    logic [Y_W:0]   y_room;
    logic [Y_W:0]   eff_h;
    logic [X_W-1:0] x_last_cmd;
    logic [Y_W-1:0] y_last_cmd;
    logic           empty_cmd;
    logic           accept;
    logic           xfer;
    logic           last_pixel;

    // Clipping runs one bit wider than the coordinates so no sum can wrap.
    always_comb begin
        x_room     = SCREEN_W_EXT - {1'b0, iX};
        y_room     = SCREEN_H_EXT - {1'b0, iY};
        eff_w      = ({1'b0, iXs} < x_room) ? {1'b0, iXs} : x_room;
        eff_h      = ({1'b0, iYs} < y_room) ? {1'b0, iYs} : y_room;
        empty_cmd  = ({1'b0, iX} >= SCREEN_W_EXT) || ({1'b0, iY} >= SCREEN_H_EXT) ||
                     (eff_w == '0) || (eff_h == '0);
        // The true last coordinate is on screen, so modulo arithmetic is exact here.
        x_last_cmd = iX + eff_w[X_W-1:0] - 1'b1;
        y_last_cmd = iY + eff_h[Y_W-1:0] - 1'b1;
    end

    assign accept     = iCmdValid && oCmdReady;
    assign xfer       = oPlot && iPixReady;
    assign last_pixel = (x_reg == x_last_reg) && (y_reg == y_last_reg);

    // Next scan position; interior outline rows skip straight to the right column.
    always_comb begin
        x_next = x_reg + 1'b1;
        y_next = y_reg;
        if (x_reg == x_last_reg) begin
            x_next = x_first_reg;
            y_next = y_reg + 1'b1;
        end else if (outline_reg && (y_reg != y_first_reg) && (y_reg != y_last_reg)) begin
            x_next = x_last_reg;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        oCmdReady  = 1'b0;
        oPlot      = 1'b0;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        case (state_reg)
            IDLE: begin
                oCmdReady = armed_reg;
                if (iCmdValid && armed_reg) begin
                    state_next = empty_cmd ? DONE : DRAW;
                end
            end
            DRAW: begin
                oPlot = 1'b1;
                oBusy = 1'b1;
                if (iPixReady && last_pixel) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                oBusy      = 1'b1;
                oDone      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Position registers double as the pixel outputs, so they only move on a
    // transfer that has a successor and otherwise keep the last emitted pixel.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            armed_reg   <= 1'b0;
            x_reg       <= '0;
            x_first_reg <= '0;
            x_last_reg  <= '0;
            y_reg       <= '0;
            y_first_reg <= '0;
            y_last_reg  <= '0;
            colour_reg  <= '0;
            outline_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            if (accept && !empty_cmd) begin
                x_reg       <= iX;
                x_first_reg <= iX;
                x_last_reg  <= x_last_cmd;
                y_reg       <= iY;
                y_first_reg <= iY;
                y_last_reg  <= y_last_cmd;
                colour_reg  <= iColour;
                outline_reg <= iMode;
            end else if (xfer && !last_pixel) begin
                x_reg <= x_next;
                y_reg <= y_next;
            end
        end
    end

    assign oX      = x_reg;
    assign oY      = y_reg;
    assign oColour = colour_reg;

endmodule

// File: tb/tb_rect_raster_engine.sv
// Randomised bench for rect_raster_engine: a pixel-list model built at command
// acceptance is compared against the DUT outputs on every falling clock edge.
module tb_rect_raster_engine;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    logic           iClock    = 1'b0;
    logic           iReset    = 1'b1;
    logic           iCmdValid = 1'b0;
    logic           oCmdReady;
    logic [X_W-1:0] iX        = '0;
    logic [Y_W-1:0] iY        = '0;
    logic [X_W-1:0] iXs       = '0;
    logic [Y_W-1:0] iYs       = '0;
    logic [C_W-1:0] iColour   = '0;
    logic           iMode     = 1'b0;
    logic           oPlot;
    logic           iPixReady = 1'b1;
    logic [X_W-1:0] oX;
    logic [Y_W-1:0] oY;
    logic [C_W-1:0] oColour;
    logic           oBusy;
    logic           oDone;

    rect_raster_engine #(
        .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .iClock(iClock), .iReset(iReset), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iX(iX), .iY(iY), .iXs(iXs), .iYs(iYs), .iColour(iColour), .iMode(iMode),
        .oPlot(oPlot), .iPixReady(iPixReady), .oX(oX), .oY(oY), .oColour(oColour),
        .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: every pixel of the clipped rectangle in row-major order, filtered
    // to the border when drawing an outline.
    typedef struct { int x; int y; } pix_t;
    pix_t pix_q[$];

    function automatic void build_model(input int x, input int y, input int xs,
                                        input int ys, input int outline);
        int ew;
        int eh;
        pix_q.delete();
        ew = (x >= SCREEN_W) ? 0 : ((xs < SCREEN_W - x) ? xs : SCREEN_W - x);
        eh = (y >= SCREEN_H) ? 0 : ((ys < SCREEN_H - y) ? ys : SCREEN_H - y);
        for (int yy = y; yy < y + eh; yy++) begin
            for (int xx = x; xx < x + ew; xx++) begin
                if (outline == 0 || yy == y || yy == y + eh - 1 || xx == x || xx == x + ew - 1)
                    pix_q.push_back('{xx, yy});
            end
        end
    endfunction

    // Pixel sink: scripted ready pattern first, otherwise random at ready_pct.
    int ready_pct = 100;
    bit ready_script[$];

    always @(posedge iClock) begin
        #1;
        if (ready_script.size() > 0) iPixReady = ready_script.pop_front();
        else iPixReady = ($urandom_range(99) < ready_pct);
    end

    // Compare process.
    bit             in_cmd = 1'b0;
    bit             armed = 1'b0;
    int             cyc = 0;
    int             cmd_no = 0;
    int             emitted = 0;
    int             cmd_mode = 0;
    logic [C_W-1:0] exp_colour = '0;
    int             last_x = 0;
    int             last_y = 0;
    int             last_c = 0;
    bit             prev_stall = 1'b0;
    int             prev_x = 0;
    int             prev_y = 0;

    always @(negedge iClock) begin
        bit exp_plot;
        bit exp_done;
        bit exp_ready;
        if (iReset) begin
            chk("rst_plot", oPlot, 0);
            chk("rst_done", oDone, 0);
            chk("rst_busy", oBusy, 0);
            chk("rst_ready", oCmdReady, 0);
            chk("rst_x", oX, 0);
            chk("rst_y", oY, 0);
            chk("rst_colour", oColour, 0);
            in_cmd = 0;
            armed = 0;
            pix_q.delete();
            last_x = 0;
            last_y = 0;
            last_c = 0;
            prev_stall = 0;
        end else begin
            if (in_cmd) cyc++;
            exp_plot  = in_cmd && (pix_q.size() > 0);
            exp_done  = in_cmd && (pix_q.size() == 0) && (cyc > 0);
            exp_ready = !in_cmd && armed;
            chk("plot", oPlot, exp_plot);
            chk("done", oDone, exp_done);
            chk("busy", oBusy, in_cmd);
            chk("cmd_ready", oCmdReady, exp_ready);
            if (prev_stall) begin
                chk("stall_hold_x", oX, prev_x);
                chk("stall_hold_y", oY, prev_y);
            end
            if (oPlot && pix_q.size() > 0) begin
                chk("pix_x", oX, pix_q[0].x);
                chk("pix_y", oY, pix_q[0].y);
                chk("pix_colour", oColour, exp_colour);
                if (iPixReady) begin
                    last_x = pix_q[0].x;
                    last_y = pix_q[0].y;
                    last_c = exp_colour;
                    void'(pix_q.pop_front());
                    emitted++;
                end
            end else if (!oPlot) begin
                chk("idle_hold_x", oX, last_x);
                chk("idle_hold_y", oY, last_y);
                chk("idle_hold_colour", oColour, last_c);
            end
            prev_stall = oPlot && !iPixReady;
            prev_x = oX;
            prev_y = oY;
            if (exp_done) begin
                $display("cmd %0d done: mode=%0d pixels=%0d cycles=%0d",
                         cmd_no, cmd_mode, emitted, cyc);
                in_cmd = 0;
            end
            if (exp_ready && iCmdValid) begin
                build_model(iX, iY, iXs, iYs, iMode);
                exp_colour = iColour;
                cmd_mode = iMode;
                in_cmd = 1;
                cyc = 0;
                emitted = 0;
                cmd_no++;
            end
            armed = 1;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!oCmdReady && n < 20000) begin
            @(posedge iClock);
            #1;
            n++;
        end
        chk("ready_timeout", oCmdReady, 1);
    endtask

    task automatic send(input int x, input int y, input int xs, input int ys,
                        input int col, input int mode);
        wait_ready();
        iX = X_W'(x);
        iY = Y_W'(y);
        iXs = X_W'(xs);
        iYs = Y_W'(ys);
        iColour = C_W'(col);
        iMode = mode[0];
        iCmdValid = 1'b1;
        @(posedge iClock);
        #1;
        // Scramble the fields so any late sampling of the inputs shows up.
        iCmdValid = 1'b0;
        iX = X_W'($urandom);
        iY = Y_W'($urandom);
        iXs = X_W'($urandom);
        iYs = Y_W'($urandom);
        iColour = C_W'($urandom);
        iMode = 1'($urandom);
    endtask

    initial begin
        build_model(1, 10, 5, 3, 0);
        chk("model_fill_count", pix_q.size(), 15);
        chk("model_fill_last_x", pix_q[14].x, 5);
        chk("model_fill_last_y", pix_q[14].y, 12);
        build_model(0, 0, 4, 4, 1);
        chk("model_outline_count", pix_q.size(), 12);
        chk("model_outline_row1_right", pix_q[5].x, 3);
        build_model(318, 238, 6, 5, 0);
        chk("model_clip_count", pix_q.size(), 4);
        chk("model_clip_second_x", pix_q[1].x, 319);
        build_model(5, 5, 0, 3, 0);
        chk("model_zero_count", pix_q.size(), 0);
        build_model(320, 5, 3, 3, 0);
        chk("model_offscreen_count", pix_q.size(), 0);
        build_model(10, 10, 10, 5, 1);
        chk("model_outline_10x5", pix_q.size(), 26);
        pix_q.delete();

        repeat (3) @(posedge iClock);
        #1;
        iReset = 1'b0;

        ready_pct = 100;
        send(1, 10, 5, 3, 3'b100, 0);
        send(0, 0, 4, 4, 2, 1);
        send(318, 238, 6, 5, 5, 0);
        send(30, 40, 0, 3, 1, 0);
        send(320, 40, 3, 3, 1, 0);
        send(100, 200, 2, 7, 6, 1);

        wait_ready();
        ready_script = '{1'b1, 1'b0, 1'b0, 1'b1};
        send(50, 60, 2, 1, 7, 0);

        // Reset while the 7th pixel of a 5x3 fill is on the bus.
        wait_ready();
        ready_pct = 100;
        send(10, 20, 5, 3, 3, 0);
        repeat (6) @(posedge iClock);
        #1;
        iReset = 1'b1;
        #1;
        chk("mid_reset_plot", oPlot, 0);
        chk("mid_reset_done", oDone, 0);
        repeat (2) @(posedge iClock);
        #1;
        iReset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int x;
            int y;
            int xs;
            int ys;
            ready_pct = (i % 3 == 0) ? 100 : ((i % 3 == 1) ? 60 : 30);
            x  = ($urandom_range(3) == 0) ? $urandom_range(330, 300) : $urandom_range(319);
            y  = ($urandom_range(3) == 0) ? $urandom_range(245, 225) : $urandom_range(239);
            xs = $urandom_range(20);
            ys = $urandom_range(12);
            if (i % 7 == 0) begin
                xs = $urandom_range(511, 300);
                ys = $urandom_range(3);
            end
            send(x, y, xs, ys, $urandom_range(7), $urandom_range(1));
        end

        wait_ready();
        repeat (3) @(posedge iClock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_raster_engine.md
RECT_RASTER_ENGINE -- requirements
Module: rect_raster_engine

Interface
REQ-001 Parameter X_W, default 9, sets the X coordinate and width bit count.
REQ-002 Parameter Y_W, default 8, sets the Y coordinate and height bit count.
REQ-003 Parameter C_W, default 3, sets the colour bit count.
REQ-004 Parameter SCREEN_W, default 320, is the visible width; pixels with x >= SCREEN_W are never emitted.
REQ-005 Parameter SCREEN_H, default 240, is the visible height; pixels with y >= SCREEN_H are never emitted.
REQ-006 Ports SHALL be:
- iClock  in  1  clock; all state changes on its rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iCmdValid  in  1  command present.
- oCmdReady  out  1  engine can accept a command.
- iX  in  X_W  left edge.
- iY  in  Y_W  top edge.
- iXs  in  X_W  width in pixels.
- iYs  in  Y_W  height in pixels.
- iColour  in  C_W  fill colour.
- iMode  in  1  0 = solid fill, 1 = outline only.
- oPlot  out  1  pixel valid.
- iPixReady  in  1  sink accepts the pixel.
- oX  out  X_W  pixel x.
- oY  out  Y_W  pixel y.
- oColour  out  C_W  pixel colour.
- oBusy  out  1  command in progress.
- oDone  out  1  one-cycle completion pulse.

Function
REQ-007 The engine SHALL use the states IDLE, DRAW and DONE.
REQ-008 oCmdReady SHALL be 1 only in IDLE.
REQ-009 A command SHALL be accepted on a rising edge with iCmdValid=1 and oCmdReady=1, and all command fields SHALL be latched on that edge.
REQ-010 Input changes after acceptance SHALL have no effect on the command in progress.
REQ-011 Clipping SHALL be applied at acceptance using X_W+1 and Y_W+1 bit arithmetic, so no sum wraps:
- effective width = min(iXs, SCREEN_W-iX);
- effective height = min(iYs, SCREEN_H-iY).
REQ-012 If the effective width or height is 0, or iX>=SCREEN_W, or iY>=SCREEN_H, the engine SHALL go IDLE->DONE with no oPlot.
REQ-013 Otherwise the engine SHALL go IDLE->DRAW, and oPlot SHALL be 1 on the first pixel in the cycle after acceptance.
REQ-014 In DRAW the engine SHALL scan row-major, x ascending from iX and then y ascending from iY.
REQ-015 A pixel SHALL transfer on a rising edge with oPlot=1 and iPixReady=1.
REQ-016 While oPlot=1 and iPixReady=0, oX, oY and oColour SHALL hold stable.
REQ-017 With iPixReady held at 1, throughput SHALL be one pixel per cycle with no bubbles, including across row changes.
REQ-018 In outline mode the engine SHALL emit only pixels on the first or last row or the first or last column of the clipped rectangle.
REQ-019 On interior rows in outline mode, the engine SHALL jump directly from the left column to the right column, with no idle cycles.
REQ-020 Outline mode with effective width <=2 or height <=2 SHALL emit the same pixel set as fill mode.
REQ-021 In outline mode, clipped edges SHALL be treated as rectangle edges.
REQ-022 After the last pixel transfers, the engine SHALL enter DONE.
REQ-023 DONE SHALL last exactly one cycle, with oDone=1, oPlot=0 and oCmdReady=0, and SHALL then return to IDLE.
REQ-024 oBusy SHALL be 1 in DRAW and DONE, and 0 in IDLE.
REQ-025 oPlot SHALL be 0 in IDLE and DONE.
REQ-026 When oPlot=0, oX, oY and oColour SHALL retain the last emitted values.
REQ-027 Pixel count for a fill command SHALL be effective width × effective height.
REQ-028 Pixel count for an outline command SHALL be 2·w + 2·h − 4 for w,h >= 2 (w, h = effective width and height).

Reset
REQ-029 While iReset=1, regardless of the clock, the engine SHALL be in IDLE with oPlot=0, oDone=0, oBusy=0, oCmdReady=0, oX=0, oY=0, oColour=0, and all internal counters at 0.
REQ-030 When iReset is asserted mid-DRAW, the in-progress command SHALL be discarded, with no further pixels and no oDone.
REQ-031 oCmdReady SHALL become 1 on the first rising edge after iReset deasserts.

Verification
REQ-032 Fill iX=1, iY=10, iXs=5, iYs=3, iColour=3'b100, iPixReady=1 -> 15 consecutive oPlot cycles, starting 1 cycle after acceptance, at (1..5,10),(1..5,11),(1..5,12); oDone pulses on the next cycle.
REQ-033 Outline iX=0, iY=0, iXs=4, iYs=4 -> exactly 12 pixels: row 0 x0..3; rows 1-2 x0 and x3; row 3 x0..3; 12 plot cycles total.
REQ-034 Clip iX=318, iY=238, iXs=6, iYs=5 -> exactly 4 pixels: (318,238),(319,238),(318,239),(319,239); then oDone.
REQ-035 Zero or off-screen commands (iXs=0, or iX=320) -> no oPlot, with oDone 1 cycle after acceptance.
REQ-036 Backpressure: iPixReady toggles 1,0,0,1 during a 2x1 fill -> oX holds through the stalls; 2 pixels total; no pixel is lost or duplicated.
REQ-037 Reset mid-frame: iReset pulses at pixel 7 of a 5x3 fill -> oPlot=0 immediately; no oDone; oCmdReady=1 one edge after release.
